// File: rtl/piece_spawner.sv
// piece_spawner
//   Moves a freshly generated piece from the next-piece preview area of grid
//   memory (addresses NEXT_PIECE_BASE_ADDR..+11, 3 columns x 4 rows) onto the
//   top of the playfield. The sequence runs once per spawn request:
//     1. validate the four preview addresses,
//     2. read the four spawn cells and look for collisions,
//     3. read the piece colour from preview cell 1,
//     4. write the colour into the spawn cells, then clear the preview cells,
//     5. publish the four playfield addresses of the active piece.
//
//   Memory handshake: the block owns the single grid-memory port while en is
//   high. mem_addr/we/wr_data are registered. A read presented on mem_addr is
//   answered on rd_data one cycle after the memory samples it, so a read issued
//   at edge E is consumed at edge E+2.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   en                         spawn request (level)
//   next_addr_1..4   [7:0]     preview addresses of the four piece cells
//   rd_data          [7:0]     grid memory read data (registered read)
//   mem_addr         [7:0]     grid memory address
//   we                         grid memory write enable
//   wr_data          [7:0]     grid memory write data
//   active_addr_1..4 [7:0]     playfield addresses of the spawned piece
//   spawned                    one-cycle pulse, spawn finished
//   bad_piece                  one-cycle pulse, malformed request or colour 0
//   game_over                  sticky, spawn cells were occupied
module piece_spawner #(
  parameter logic [7:0] NEXT_PIECE_BASE_ADDR = 8'd240,
  parameter int         GRID_WIDTH           = 10,
  parameter int         SPAWN_ROW            = 0,
  parameter int         SPAWN_COL            = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] next_addr_1,
  input  logic [7:0] next_addr_2,
  input  logic [7:0] next_addr_3,
  input  logic [7:0] next_addr_4,
  input  logic [7:0] rd_data,
  output logic [7:0] mem_addr,
  output logic       we,
  output logic [7:0] wr_data,
  output logic [7:0] active_addr_1,
  output logic [7:0] active_addr_2,
  output logic [7:0] active_addr_3,
  output logic [7:0] active_addr_4,
  output logic       spawned,
  output logic       bad_piece,
  output logic       game_over
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_VALIDATE = 3'd1;
  localparam logic [2:0] S_CHECK    = 3'd2;
  localparam logic [2:0] S_COLOUR   = 3'd3;
  localparam logic [2:0] S_WRITE    = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;
  localparam logic [2:0] S_WAIT_LOW = 3'd6;

  logic [2:0] state;
  logic [2:0] cnt;
  logic       collide;
  logic [7:0] colour;
  logic [7:0] na  [0:3];
  logic [7:0] tgt [0:3];

  // Preview offset -> playfield address. Row comes from a small constant
  // table so no divider is built; out-of-range offsets map to 0 and are
  // rejected in VALIDATE anyway.
  function automatic logic [7:0] map_tgt(input logic [7:0] a);
    logic [7:0] off;
    logic [7:0] row;
    logic [7:0] col;
    off = a - NEXT_PIECE_BASE_ADDR;
    row = 8'd0;
    case (off)
      8'd0, 8'd1, 8'd2:   row = 8'd0;
      8'd3, 8'd4, 8'd5:   row = 8'd1;
      8'd6, 8'd7, 8'd8:   row = 8'd2;
      8'd9, 8'd10, 8'd11: row = 8'd3;
      default:            row = 8'd0;
    endcase
    col = (off > 8'd11) ? 8'd0 : 8'(off - 8'(row * 8'd3));
    return 8'((SPAWN_ROW + int'(row)) * GRID_WIDTH + SPAWN_COL + int'(col));
  endfunction

  function automatic logic in_range(input logic [7:0] a);
    return (a >= NEXT_PIECE_BASE_ADDR) && (a <= NEXT_PIECE_BASE_ADDR + 8'd11);
  endfunction

  logic addrs_ok;
  assign addrs_ok = in_range(na[0]) && in_range(na[1]) &&
                    in_range(na[2]) && in_range(na[3]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= 3'd0;
      collide       <= 1'b0;
      colour        <= 8'd0;
      mem_addr      <= 8'd0;
      we            <= 1'b0;
      wr_data       <= 8'd0;
      active_addr_1 <= 8'd0;
      active_addr_2 <= 8'd0;
      active_addr_3 <= 8'd0;
      active_addr_4 <= 8'd0;
      spawned       <= 1'b0;
      bad_piece     <= 1'b0;
      game_over     <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        na[i]  <= 8'd0;
        tgt[i] <= 8'd0;
      end
    end else begin
      spawned   <= 1'b0;
      bad_piece <= 1'b0;
      case (state)
        S_IDLE: begin
          we <= 1'b0;
          if (en) begin
            if (game_over) begin
              state <= S_WAIT_LOW;
            end else begin
              na[0]  <= next_addr_1;
              na[1]  <= next_addr_2;
              na[2]  <= next_addr_3;
              na[3]  <= next_addr_4;
              tgt[0] <= map_tgt(next_addr_1);
              tgt[1] <= map_tgt(next_addr_2);
              tgt[2] <= map_tgt(next_addr_3);
              tgt[3] <= map_tgt(next_addr_4);
              state  <= S_VALIDATE;
            end
          end
        end
        S_VALIDATE: begin
          if (!addrs_ok) begin
            bad_piece <= 1'b1;
            state     <= S_WAIT_LOW;
          end else begin
            // First spawn-cell read is issued here so the 8 CHECK cycles
            // cover exactly four issue/sample pairs.
            mem_addr <= tgt[0];
            cnt      <= 3'd0;
            collide  <= 1'b0;
            state    <= S_CHECK;
          end
        end
        S_CHECK: begin
          cnt <= cnt + 3'd1;
          // Odd counts consume the read issued two edges earlier.
          if (cnt[0]) begin
            if (rd_data != 8'd0) collide <= 1'b1;
            if (cnt == 3'd7) begin
              if (collide || (rd_data != 8'd0)) begin
                game_over <= 1'b1;
                state     <= S_WAIT_LOW;
              end else begin
                mem_addr <= na[0];
                cnt      <= 3'd0;
                state    <= S_COLOUR;
              end
            end else begin
              mem_addr <= tgt[cnt[2:1] + 2'd1];
            end
          end
        end
        S_COLOUR: begin
          cnt <= cnt + 3'd1;
          if (cnt == 3'd1) begin
            if (rd_data == 8'd0) begin
              bad_piece <= 1'b1;
              state     <= S_WAIT_LOW;
            end else begin
              colour <= rd_data;
              cnt    <= 3'd0;
              state  <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          we  <= 1'b1;
          cnt <= cnt + 3'd1;
          if (!cnt[2]) begin
            mem_addr <= tgt[cnt[1:0]];
            wr_data  <= colour;
          end else begin
            mem_addr <= na[cnt[1:0]];
            wr_data  <= 8'd0;
          end
          if (cnt == 3'd7) state <= S_DONE;
        end
        S_DONE: begin
          we            <= 1'b0;
          spawned       <= 1'b1;
          active_addr_1 <= tgt[0];
          active_addr_2 <= tgt[1];
          active_addr_3 <= tgt[2];
          active_addr_4 <= tgt[3];
          state         <= S_WAIT_LOW;
        end
        S_WAIT_LOW: begin
          we <= 1'b0;
          if (!en) state <= S_IDLE;
        end
        default: begin
          we    <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piece_spawner.sv
// Directed bench for piece_spawner with a behavioural grid memory
// (registered read, write on we) and a write-trace scoreboard.
module tb_piece_spawner;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] next_addr_1, next_addr_2, next_addr_3, next_addr_4;
  logic [7:0] rd_data;
  logic [7:0] mem_addr;
  logic       we;
  logic [7:0] wr_data;
  logic [7:0] active_addr_1, active_addr_2, active_addr_3, active_addr_4;
  logic       spawned;
  logic       bad_piece;
  logic       game_over;

  piece_spawner dut (
    .clk(clk), .rst(rst), .en(en),
    .next_addr_1(next_addr_1), .next_addr_2(next_addr_2),
    .next_addr_3(next_addr_3), .next_addr_4(next_addr_4),
    .rd_data(rd_data), .mem_addr(mem_addr), .we(we), .wr_data(wr_data),
    .active_addr_1(active_addr_1), .active_addr_2(active_addr_2),
    .active_addr_3(active_addr_3), .active_addr_4(active_addr_4),
    .spawned(spawned), .bad_piece(bad_piece), .game_over(game_over)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // grid memory model and activity monitor
  logic [7:0]  mem [0:255];
  logic        clr, pk;
  logic [7:0]  pk_addr, pk_data;
  logic [15:0] act_q[$];
  logic [15:0] exp_q[$];
  int          we_cnt, bad_cnt, spawn_cnt;

  initial begin
    we_cnt = 0; bad_cnt = 0; spawn_cnt = 0;
  end

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'd0;
    end else if (pk) begin
      mem[pk_addr] <= pk_data;
    end else if (we) begin
      mem[mem_addr] <= wr_data;
    end
    rd_data <= mem[mem_addr];
    if (we) begin
      act_q.push_back({mem_addr, wr_data});
      we_cnt = we_cnt + 1;
    end
    if (bad_piece) bad_cnt = bad_cnt + 1;
    if (spawned) spawn_cnt = spawn_cnt + 1;
  end

  int total, bad, act_base;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    pk = 1'b1; pk_addr = a; pk_data = d;
    tick();
    pk = 1'b0;
  endtask

  task automatic set_piece(input logic [7:0] a1, input logic [7:0] a2,
                           input logic [7:0] a3, input logic [7:0] a4,
                           input logic [7:0] c);
    next_addr_1 = a1; next_addr_2 = a2; next_addr_3 = a3; next_addr_4 = a4;
    poke(a1, c); poke(a2, c); poke(a3, c); poke(a4, c);
  endtask

  // Raises en; counts edges from the latching edge (cycle 0) until spawned is
  // seen. drop_at >= 0 lowers en after that cycle. lat = -1 on timeout.
  task automatic run_spawn(input int drop_at, output int lat);
    lat = -1;
    en = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (c == drop_at) en = 1'b0;
      if (spawned) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic run_window(input int n);
    en = 1'b1;
    repeat (n) tick();
    en = 1'b0;
    repeat (2) tick();
  endtask

  task automatic exp_spawn(input logic [7:0] t1, input logic [7:0] t2,
                           input logic [7:0] t3, input logic [7:0] t4,
                           input logic [7:0] c);
    exp_q.push_back({t1, c}); exp_q.push_back({t2, c});
    exp_q.push_back({t3, c}); exp_q.push_back({t4, c});
    exp_q.push_back({next_addr_1, 8'd0}); exp_q.push_back({next_addr_2, 8'd0});
    exp_q.push_back({next_addr_3, 8'd0}); exp_q.push_back({next_addr_4, 8'd0});
  endtask

  task automatic check_writes(input string tag);
    int n;
    n = act_q.size() - act_base;
    check({tag, "_nwrites"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++)
      check({tag, "_write"}, act_q[act_base + i], exp_q[i]);
    act_base = act_q.size();
    exp_q.delete();
  endtask

  task automatic check_active(input string tag, input logic [7:0] t1, input logic [7:0] t2,
                              input logic [7:0] t3, input logic [7:0] t4);
    check({tag, "_active1"}, active_addr_1, t1);
    check({tag, "_active2"}, active_addr_2, t2);
    check({tag, "_active3"}, active_addr_3, t3);
    check({tag, "_active4"}, active_addr_4, t4);
  endtask

  int lat, w0, b0, s0;

  initial begin
    total = 0; bad = 0; act_base = 0;
    rst = 1'b1; en = 1'b0; clr = 1'b0; pk = 1'b0; pk_addr = 8'd0; pk_data = 8'd0;
    next_addr_1 = 8'd0; next_addr_2 = 8'd0; next_addr_3 = 8'd0; next_addr_4 = 8'd0;
    clear_mem();
    repeat (2) tick();

    // reset state
    check("rst_we", we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_spawned", spawned, 0);
    check("rst_bad_piece", bad_piece, 0);
    check("rst_game_over", game_over, 0);
    check_active("rst", 0, 0, 0, 0);
    rst = 1'b0;
    tick();

    // I piece
    clear_mem();
    set_piece(8'd240, 8'd243, 8'd246, 8'd249, 8'd1);
    exp_spawn(8'd3, 8'd13, 8'd23, 8'd33, 8'd1);
    run_spawn(-1, lat);
    check("i_latency", lat, 20);
    check_active("i", 8'd3, 8'd13, 8'd23, 8'd33);
    en = 1'b0;
    tick();
    check("i_spawn_pulse", spawned, 0);
    check_writes("i");
    check("i_mem3", mem[3], 1);
    check("i_mem240", mem[240], 0);
    check("i_mem249", mem[249], 0);
    tick();

    // T piece
    clear_mem();
    set_piece(8'd244, 8'd246, 8'd247, 8'd250, 8'd3);
    exp_spawn(8'd14, 8'd23, 8'd24, 8'd34, 8'd3);
    run_spawn(-1, lat);
    check("t_latency", lat, 20);
    check_active("t", 8'd14, 8'd23, 8'd24, 8'd34);
    en = 1'b0;
    repeat (2) tick();
    check_writes("t");
    check("t_mem244", mem[244], 0);
    check("t_mem250", mem[250], 0);
    check("t_mem34", mem[34], 3);

    // collision: O piece over an occupied cell 24
    clear_mem();
    set_piece(8'd246, 8'd247, 8'd249, 8'd250, 8'd2);
    poke(8'd24, 8'd5);
    w0 = we_cnt; s0 = spawn_cnt;
    run_window(40);
    check("col_game_over", game_over, 1);
    check("col_we_cycles", we_cnt - w0, 0);
    check("col_spawned", spawn_cnt - s0, 0);
    check_active("col_hold", 8'd14, 8'd23, 8'd24, 8'd34);
    w0 = we_cnt;
    poke(8'd24, 8'd0);
    run_window(40);
    check("col2_we_cycles", we_cnt - w0, 0);
    check("col2_game_over", game_over, 1);
    rst = 1'b1;
    tick();
    check("col_rst_game_over", game_over, 0);
    rst = 1'b0;
    tick();
    act_base = act_q.size();

    // bad address
    clear_mem();
    set_piece(8'd240, 8'd243, 8'd246, 8'd249, 8'd4);
    next_addr_3 = 8'd252;
    w0 = we_cnt; b0 = bad_cnt;
    run_window(40);
    check("badaddr_pulses", bad_cnt - b0, 1);
    check("badaddr_we", we_cnt - w0, 0);
    check("badaddr_game_over", game_over, 0);

    // bad colour: valid addresses, preview colour 0
    clear_mem();
    next_addr_1 = 8'd240; next_addr_2 = 8'd241; next_addr_3 = 8'd242; next_addr_4 = 8'd243;
    w0 = we_cnt; b0 = bad_cnt;
    run_window(40);
    check("badcol_pulses", bad_cnt - b0, 1);
    check("badcol_we", we_cnt - w0, 0);

    // en dropped at cycle 12: sequence still completes (S piece)
    clear_mem();
    set_piece(8'd241, 8'd242, 8'd243, 8'd244, 8'd6);
    exp_spawn(8'd4, 8'd5, 8'd13, 8'd14, 8'd6);
    run_spawn(12, lat);
    check("drop_latency", lat, 20);
    check_active("drop", 8'd4, 8'd5, 8'd13, 8'd14);
    en = 1'b0;
    repeat (2) tick();
    check_writes("drop");

    // reset mid-WRITE after two writes
    clear_mem();
    set_piece(8'd240, 8'd243, 8'd246, 8'd249, 8'd7);
    exp_q.push_back({8'd3, 8'd7});
    exp_q.push_back({8'd13, 8'd7});
    en = 1'b1;
    for (int c = 0; c <= 13; c++) tick();
    rst = 1'b1; en = 1'b0;
    tick();
    check("mrst_we", we, 0);
    check("mrst_mem_addr", mem_addr, 0);
    check("mrst_wr_data", wr_data, 0);
    check("mrst_spawned", spawned, 0);
    check("mrst_game_over", game_over, 0);
    check_active("mrst", 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    check_writes("mrst");

    // fresh spawn after reset
    clear_mem();
    set_piece(8'd240, 8'd243, 8'd246, 8'd249, 8'd7);
    exp_spawn(8'd3, 8'd13, 8'd23, 8'd33, 8'd7);
    run_spawn(-1, lat);
    check("post_latency", lat, 20);
    check_active("post", 8'd3, 8'd13, 8'd23, 8'd33);
    en = 1'b0;
    repeat (2) tick();
    check_writes("post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piece_spawner.md
Name: piece_spawner

Overview:
- Downstream of the next-piece generator. Once a piece is written into the next-piece preview area of grid memory (addresses 240..251), this block moves it onto the playfield.
- On `en` it does four things, in order:
  - checks the four spawn cells for collision;
  - copies the piece colour into the spawn cells at the top of the playfield;
  - clears the four preview cells;
  - publishes the four active-piece playfield addresses for the movement logic.
- Drives the single shared grid-memory port while `en` is high. The arbiter gives the port to this block only then.

Parameters:
- `NEXT_PIECE_BASE_ADDR`, 8'd240: first preview cell. Preview is 3 columns x 4 rows; offset = row*3 + col.
- `GRID_WIDTH`, 10: playfield cells per row.
- `SPAWN_ROW`, 0: playfield row where preview row 0 lands.
- `SPAWN_COL`, 3: playfield column where preview column 0 lands.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset. Synchronous, active-high.
- `en` in 1: spawn request (level). The block owns the memory port while high.
- `next_addr_1`..`next_addr_4` in 8 each: preview addresses of the four piece cells, from the generator.
- `rd_data` in 8: grid memory read data. Registered read: valid the cycle after `mem_addr` is presented.
- `mem_addr` out 8: grid memory address, registered.
- `we` out 1: grid memory write enable, registered.
- `wr_data` out 8: grid memory write data, registered.
- `active_addr_1`..`active_addr_4` out 8 each: playfield addresses of the spawned piece.
- `spawned` out 1: one-cycle pulse when a spawn completes.
- `bad_piece` out 1: one-cycle pulse when the request is malformed.
- `game_over` out 1: sticky; cleared only by `rst`.

Behaviour:
- Reset (synchronous, active-high, also mid-operation):
  - All outputs go to 0, state goes to IDLE, on the next edge.
  - No write can be issued in the cycle after `rst` is sampled.
- Address map, per cell i:
  - off = next_addr_i - NEXT_PIECE_BASE_ADDR; row = off/3; col = off%3.
  - tgt_i = (SPAWN_ROW+row)*GRID_WIDTH + SPAWN_COL + col, computed in 8 bits.
  - off must be in 0..11; use a constant lookup, not a divider.
- IDLE:
  - `we`=0.
  - `en`=1 sampled: latch `next_addr_1..4`, compute tgt_1..4, go to VALIDATE.
- VALIDATE (1 cycle): if any next_addr is outside 240..251, pulse `bad_piece`, make no writes, and go to WAIT_LOW. Otherwise go to CHECK.
- CHECK (8 cycles):
  - For i = 1..4: present `mem_addr`=tgt_i with `we`=0, then sample `rd_data` the following cycle.
  - Any nonzero sample sets the collide flag.
  - If collide is set after cell 4: set `game_over`=1, make no writes, go to WAIT_LOW.
- COLOUR (2 cycles):
  - Present `mem_addr`=next_addr_1 and sample `rd_data` as the colour.
  - Colour 0 → pulse `bad_piece`, no writes, go to WAIT_LOW.
- WRITE (8 cycles, `we`=1 each cycle, one cell per cycle, fixed order):
  - tgt_1..tgt_4 with `wr_data`=colour;
  - then next_addr_1..4 with `wr_data`=0.
- DONE (1 cycle):
  - `we`=0, `spawned`=1.
  - `active_addr_1..4` take tgt_1..4 on this edge and hold until the next successful spawn or `rst`.
  - Go to WAIT_LOW.
- WAIT_LOW: hold with `we`=0; return to IDLE when `en`=0.
- Atomicity: `en` falling mid-sequence is ignored. The sequence completes, so a half-written piece never exists.
- `game_over`=1: every later `en` goes straight to WAIT_LOW with no memory access.
- Latency: `spawned` is high exactly 20 cycles after the first `en`=1 sample in IDLE. That is 1 latch + 1 validate + 8 check + 2 colour + 8 write, with DONE on the 20th.
- `mem_addr` holds its last value when idle.

Test Plan:
- I piece. Stimulus: `next_addr`=240,243,246,249, preview colour 1, empty playfield, `en`=1. Required:
  - writes 3,13,23,33 ← 1, then 240,243,246,249 ← 0;
  - `spawned` pulse at cycle 20;
  - `active_addr`=3,13,23,33.
- T piece. Stimulus: `next_addr`=244,246,247,250, colour 3. Required:
  - writes 14,23,24,34 ← 3;
  - preview cells cleared;
  - `active_addr`=14,23,24,34.
- Collision. Stimulus: O piece (246,247,249,250), playfield cell 24 = 5. Required:
  - `game_over`=1 and stays high;
  - zero `we` cycles;
  - a second `en` also produces zero `we` cycles.
- Bad address. Stimulus: `next_addr_3`=252. Required: one `bad_piece` pulse, zero writes. Bad colour: valid addresses with colour 0 → same response.
- `en` dropped at cycle 12. Required: all 8 writes still occur, `spawned` pulses, return to IDLE.
- `rst` asserted mid-WRITE after 2 writes. Required: next cycle `we`=0, all outputs 0, IDLE. A fresh `en` then spawns normally.
